pop_uart_tx: RTL

- Serializes one 150-bit path out of the 7500-bit population bus over a UART 8N1 line.
- Sits downstream of the state controller: triggered by its uart_transmit strobe; drives the top-level uart_out pin.
- Frame stream: header byte 0xA5, then the path as 19 data bytes, LSB first.

---
 rtl/pop_uart_tx_if.sv | 24 ++
 rtl/pop_uart_tx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pop_uart_tx_if.sv
// pop_uart_tx_if: request/population bus and status lines between the state
// controller (master) and the population UART transmitter (slave).
interface pop_uart_tx_if #(
  parameter int PATH_BITS = 150,
  parameter int NUM_PATHS = 50
);
  logic                           start;
  logic [5:0]                     path_sel;
  logic [PATH_BITS*NUM_PATHS-1:0] population;
  logic                           uart_out;
  logic                           busy;
  logic                           done;
  logic                           err;

  modport master (
    output start, path_sel, population,
    input  uart_out, busy, done, err
  );

  modport slave (
    input  start, path_sel, population,
    output uart_out, busy, done, err
  );
endinterface

// File: rtl/pop_uart_tx.sv
// pop_uart_tx: sends one path of the population bus as a stream of UART 8N1
// frames: header 0xA5, then the path LSB-first as byte-wide frames.
// Optional macro POP_UART_CHECKSUM_EN appends a frame holding the XOR of all
// data bytes (header excluded).
//
// state     | meaning
// IDLE      | waiting for start; also emits the reject done pulse
// START_BIT | line low for one bit time (first cycle after accept: launch)
// DATA      | eight data bits, LSB first
// STOP_BIT  | line high for one bit time, then next frame or FINISH
// FINISH    | one-cycle done pulse, busy low
module pop_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PATH_BITS    = 150,
  parameter int NUM_PATHS    = 50
) (
  input logic          clk,
  input logic          reset,
  pop_uart_tx_if.slave bus
);

  localparam int DATA_BYTES = (PATH_BITS + 7) / 8;
  localparam int REG_BITS   = DATA_BYTES * 8;
  localparam int CNT_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
`ifdef POP_UART_CHECKSUM_EN
  localparam int FRAMES     = DATA_BYTES + 2;
`else
  localparam int FRAMES     = DATA_BYTES + 1;
`endif
  localparam int FRAME_W    = $clog2(FRAMES);
  localparam logic [7:0] HEADER = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA,
    STOP_BIT,
    FINISH
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    bit_cnt;
  logic [2:0]          bit_idx;
  logic [FRAME_W-1:0]  byte_cnt;
  logic [REG_BITS-1:0] path_reg;
  logic [7:0]          tx_byte;
  logic                launch;
  logic                rej_pend;
  logic                uart_r;
  logic                busy_r;
  logic                done_r;
  logic                err_r;
`ifdef POP_UART_CHECKSUM_EN
  logic [7:0]          csum;
`endif

  logic [PATH_BITS-1:0] sel_path;
  logic                 sel_ok;
  logic                 bit_end;
  logic                 last_frame;

  assign sel_path   = bus.population[32'(bus.path_sel) * PATH_BITS +: PATH_BITS];
  assign sel_ok     = (32'(bus.path_sel) < NUM_PATHS);
  assign bit_end    = (bit_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign last_frame = (byte_cnt == FRAME_W'(FRAMES - 1));

  assign bus.uart_out = uart_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.err      = err_r;

  // Transmit sequencer: bit timing, frame sequencing and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      byte_cnt <= '0;
      path_reg <= '0;
      tx_byte  <= '0;
      launch   <= 1'b0;
      rej_pend <= 1'b0;
      uart_r   <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
`ifdef POP_UART_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // A rejected request answers with done one cycle later.
          done_r   <= rej_pend;
          rej_pend <= 1'b0;
          if (bus.start) begin
            if (sel_ok) begin
              path_reg <= REG_BITS'(sel_path);
              tx_byte  <= HEADER;
              err_r    <= 1'b0;
              busy_r   <= 1'b1;
              byte_cnt <= '0;
              bit_cnt  <= '0;
              bit_idx  <= '0;
              launch   <= 1'b1;
              state    <= START_BIT;
`ifdef POP_UART_CHECKSUM_EN
              csum     <= '0;
`endif
            end else begin
              err_r    <= 1'b1;
              rej_pend <= 1'b1;
            end
          end
        end

        START_BIT: begin
          if (launch) begin
            launch  <= 1'b0;
            uart_r  <= 1'b0;
            bit_cnt <= '0;
          end else if (bit_end) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            uart_r  <= tx_byte[0];
            tx_byte <= tx_byte >> 1;
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              uart_r <= 1'b1;
              state  <= STOP_BIT;
            end else begin
              uart_r  <= tx_byte[0];
              tx_byte <= tx_byte >> 1;
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end

        STOP_BIT: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (last_frame) begin
              done_r <= 1'b1;
              busy_r <= 1'b0;
              uart_r <= 1'b1;
              state  <= FINISH;
            end else begin
              // Next start bit follows the stop bit with no idle gap.
              uart_r   <= 1'b0;
              byte_cnt <= byte_cnt + FRAME_W'(1);
              state    <= START_BIT;
`ifdef POP_UART_CHECKSUM_EN
              if (byte_cnt == FRAME_W'(DATA_BYTES)) begin
                tx_byte <= csum;
              end else begin
                tx_byte  <= path_reg[7:0];
                path_reg <= path_reg >> 8;
                csum     <= csum ^ path_reg[7:0];
              end
`else
              tx_byte  <= path_reg[7:0];
              path_reg <= path_reg >> 8;
`endif
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end

        FINISH: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
